vx_dispatch_arb: RTL and testbench
==================================

VX_DISPATCH_ARB -- requirements
Module: VX_dispatch_arb

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 4: number of issue slices feeding one execute unit.
REQ-002 SHALL have parameter DATAW, default 64: dispatch payload width in bits.
REQ-003 SHALL define SEL_W = max(1, clog2(NUM_SLICES)) as a localparam.
REQ-004 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, NUM_SLICES: per-slice dispatch request.
REQ-007 SHALL have port in_data, input, NUM_SLICES*DATAW: per-slice payload; slice i occupies bits [i*DATAW +: DATAW].
REQ-008 SHALL have port in_ready, output, NUM_SLICES: per-slice accept.
REQ-009 SHALL have port out_valid, output, 1: buffered entry available to the execute unit.
REQ-010 SHALL have port out_data, output, DATAW: head-entry payload.
REQ-011 SHALL have port out_sel, output, SEL_W: issue-slice index of the head entry.
REQ-012 SHALL have port out_ready, input, 1: execute unit accepts the head entry.
REQ-013 SHALL have port perf_stalls, output, 32, present only under DISPATCH_ARB_PERF_EN.

Function
REQ-014 SHALL grant round-robin: the lowest-index valid slice at or after (ptr+1) mod NUM_SLICES.
REQ-015 SHALL drive in_ready one-hot on the granted slice when the buffer is not full, and all-zero otherwise.
REQ-016 SHALL define input fire as in_valid[i] && in_ready[i]; at most one fire per cycle.
REQ-017 SHALL set ptr to the fired index on input fire only; with no fire, ptr holds.
REQ-018 SHALL hold accepted entries {sel, data} in a 2-entry FIFO; out_valid = (count != 0).
REQ-019 SHALL assert out_valid on the cycle after the input fire (latency 1); no combinational in-to-out path.
REQ-020 SHALL NOT let in_ready depend combinationally on out_ready; a full FIFO (count==2) blocks pushes even when out_ready=1.
REQ-021 SHALL, on simultaneous push and pop at count 1, keep count at 1 and present the new entry next cycle.
REQ-022 SHALL keep out_data and out_sel stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one transfer per cycle when out_ready stays high.
REQ-024 SHALL, for NUM_SLICES=1, make out_sel constant 0 and ptr a don't-care.
REQ-025 SHALL require upstream slices to hold valid and data until ready; a slice dropping valid before fire simply loses its grant.

Reset
REQ-026 SHALL, while reset is asserted, force count=0, out_valid=0, out_data=0, out_sel=0, ptr=NUM_SLICES-1 (slice 0 wins first), perf_stalls=0.
REQ-027 SHALL drive in_ready all-zero while reset is asserted.
REQ-028 SHALL discard buffered entries on mid-operation reset, with no output fire for them afterwards.

Configuration
REQ-029 SHALL, with DISPATCH_ARB_PERF_EN defined, provide perf_stalls, incremented (wrapping) every cycle in which any in_valid is high and no input fire occurs.
REQ-030 SHALL, without DISPATCH_ARB_PERF_EN, have no perf_stalls port and no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: after reset, in_valid=4'b1111 with out_ready=1 held -> fires in order 0,1,2,3,0, and out_sel shows 0,1,2,3 one cycle later.
REQ-032 SHALL cover: out_ready=0 and in_valid=4'b0001 with data 0xA, 0xB -> two fires, then in_ready=0 and count=2; when out_ready=1, 0xA then 0xB emerge, and in_ready reasserts the cycle after the first pop.
REQ-033 SHALL cover: count=1, in_valid[2]=1, out_ready=1 -> push and pop in the same cycle, count stays 1, and out_sel=2 next cycle.
REQ-034 SHALL cover: reset asserted asynchronously with count=2 -> out_valid=0 immediately and no stale entry after release; first grant goes to slice 0.
REQ-035 SHALL cover: DISPATCH_ARB_PERF_EN on, buffer full for 5 cycles with in_valid=4'b0100 -> perf_stalls=5.
REQ-036 SHALL cover: NUM_SLICES=1, back-to-back traffic with out_ready=1 -> one transfer per cycle and out_sel=0.

Source files
------------

// File: rtl/vx_dispatch_arb.sv
// Round-robin dispatch arbiter: N issue slices feed one execute unit through a 2-entry {sel, data} FIFO.
// Optional stall counter (perf_stalls) is built only when DISPATCH_ARB_PERF_EN is defined.
module vx_dispatch_arb #(
    parameter int  NUM_SLICES = 4,
    parameter int  DATAW      = 64,
    localparam int SEL_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SLICES-1:0]       in_valid,
    input  logic [NUM_SLICES*DATAW-1:0] in_data,
    output logic [NUM_SLICES-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    input  logic                        out_ready
`ifdef DISPATCH_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_stalls
`endif
);

    logic [SEL_W-1:0]       ptr;
    logic [SEL_W-1:0]       grant_idx;
    logic [SEL_W-1:0]       lo_idx;
    logic [SEL_W-1:0]       hi_idx;
    logic                   lo_found;
    logic                   hi_found;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [DATAW-1:0]       push_data;
    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [SEL_W+DATAW-1:0] mem [2];

    // Lowest valid slice strictly above ptr wins; otherwise wrap to the lowest valid slice overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(i);
            end
            if (in_valid[i] && (i > int'(ptr))) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(i);
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Acceptance depends only on registered occupancy, never on out_ready.
    assign accept = !reset && (count != 2'd2) && lo_found;

    always_comb begin
        in_ready  = '0;
        push_data = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            in_ready[i] = accept && (grant_idx == SEL_W'(i));
            if (grant_idx == SEL_W'(i)) begin
                push_data = in_data[i*DATAW +: DATAW];
            end
        end
    end

    assign push      = |(in_valid & in_ready);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr][DATAW-1:0];
    assign out_sel   = mem[rd_ptr][SEL_W+DATAW-1:DATAW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ptr    <= SEL_W'(NUM_SLICES - 1);
            for (int e = 0; e < 2; e++) begin
                mem[e] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {grant_idx, push_data};
                wr_ptr      <= ~wr_ptr;
                ptr         <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

`ifdef DISPATCH_ARB_PERF_EN
    // Counts cycles where some slice is waiting but nothing was accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls <= 32'd0;
        end else if ((|in_valid) && !push) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed self-checking bench for vx_dispatch_arb (4-slice instance plus a 1-slice instance).
// A reference model predicts grants and pushes expected {sel, data} into a scoreboard queue.
module tb_vx_dispatch_arb;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [255:0] in_data = '0;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready = 1'b0;

    logic         in_valid1 = 1'b0;
    logic [63:0]  in_data1 = '0;
    logic         in_ready1;
    logic         out_valid1;
    logic [63:0]  out_data1;
    logic         out_sel1;
    logic         out_ready1 = 1'b0;

`ifdef DISPATCH_ARB_PERF_EN
    logic [31:0]  perf_stalls;
    logic [31:0]  perf_stalls1;
`endif

    int           n_err = 0;
    int           n_checks = 0;
    int           m_ptr = 3;
    int           m_stalls = 0;
    logic [65:0]  sb [$];
    logic [63:0]  q1 [$];

    logic [3:0]   obs_ready;
    logic         obs_valid;
    logic [1:0]   obs_sel;
    logic [63:0]  obs_data;

    vx_dispatch_arb #(.NUM_SLICES(4), .DATAW(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
`ifdef DISPATCH_ARB_PERF_EN
        , .perf_stalls(perf_stalls)
`endif
    );

    vx_dispatch_arb #(.NUM_SLICES(1), .DATAW(64)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_sel(out_sel1),
        .out_ready(out_ready1)
`ifdef DISPATCH_ARB_PERF_EN
        , .perf_stalls(perf_stalls1)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs at negedge, predict with the model, compare, then advance the model.
    task automatic applyStimulus(input logic [3:0] v, input logic ordy, input logic [63:0] dbase);
        int         g;
        int         idx;
        bit         found;
        bit         fire;
        logic [3:0] exp_ready;
        logic [65:0] head;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = dbase + 64'(i) * 64'h100;
        #1;
        found = 0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + 1 + k) % 4;
            if (!found && v[idx]) begin
                found = 1;
                g = idx;
            end
        end
        fire = found && (sb.size() < 2);
        exp_ready = fire ? 4'(1 << g) : 4'b0000;
        obs_ready = in_ready;
        obs_valid = out_valid;
        obs_sel   = out_sel;
        obs_data  = out_data;
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(sb.size() != 0));
`ifdef DISPATCH_ARB_PERF_EN
        checkOutput("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif
        if (sb.size() != 0) begin
            head = sb[0];
            checkOutput("out_sel", 64'(out_sel), 64'(head[65:64]));
            checkOutput("out_data", out_data, head[63:0]);
            if (ordy) void'(sb.pop_front());
        end
        if (fire) begin
            sb.push_back({2'(g), dbase + 64'(g) * 64'h100});
            m_ptr = g;
        end
        if ((|v) && !fire) m_stalls++;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
        repeat (2) @(negedge clk);
        in_valid = 4'b0000;
        reset = 1'b0;
        sb.delete();
        m_ptr = 3;
        m_stalls = 0;
    endtask

    initial begin
        logic [3:0] exp_order [5];
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;

        // Round-robin with all slices requesting and the consumer always ready.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 1'b1, 64'h1000 + 64'(k));
            checkOutput("rr_order", 64'(obs_ready), 64'(exp_order[k]));
            if (k > 0) checkOutput("rr_sel", 64'(obs_sel), 64'(k - 1));
        end
        applyStimulus(4'b0000, 1'b1, 64'h0);
        applyStimulus(4'b0000, 1'b1, 64'h0);

        // Fill while blocked, then drain; in_ready comes back one cycle after the first pop.
        doReset();
        applyStimulus(4'b0001, 1'b0, 64'hA);
        applyStimulus(4'b0001, 1'b0, 64'hB);
        applyStimulus(4'b0001, 1'b0, 64'hC);
        checkOutput("full_in_ready", 64'(obs_ready), 64'd0);
        checkOutput("full_hold_data", obs_data, 64'hA);
        applyStimulus(4'b0001, 1'b1, 64'hC);
        checkOutput("drain_first", obs_data, 64'hA);
        checkOutput("drain_block", 64'(obs_ready), 64'd0);
        applyStimulus(4'b0001, 1'b1, 64'hC);
        checkOutput("drain_second", obs_data, 64'hB);
        checkOutput("ready_back", 64'(obs_ready), 64'b0001);
        applyStimulus(4'b0000, 1'b1, 64'h0);
        applyStimulus(4'b0000, 1'b1, 64'h0);

        // Simultaneous push and pop at a single buffered entry.
        doReset();
        applyStimulus(4'b0001, 1'b0, 64'h50);
        applyStimulus(4'b0100, 1'b1, 64'h60);
        checkOutput("pp_grant", 64'(obs_ready), 64'b0100);
        applyStimulus(4'b0000, 1'b0, 64'h0);
        checkOutput("pp_sel", 64'(obs_sel), 64'd2);
        checkOutput("pp_valid", 64'(obs_valid), 64'd1);
        applyStimulus(4'b0000, 1'b1, 64'h0);
        applyStimulus(4'b0000, 1'b0, 64'h0);
        checkOutput("pp_count1", 64'(obs_valid), 64'd0);

        // Full buffer with a stalled slice, exercising the stall counter when present.
        doReset();
        applyStimulus(4'b0100, 1'b0, 64'h70);
        applyStimulus(4'b0100, 1'b0, 64'h80);
        for (int k = 0; k < 5; k++) applyStimulus(4'b0100, 1'b0, 64'h90);
        applyStimulus(4'b0000, 1'b0, 64'h0);
`ifdef DISPATCH_ARB_PERF_EN
        checkOutput("perf_five", 64'(perf_stalls), 64'd5);
`endif

        // Asynchronous reset mid-cycle with two entries buffered.
        @(negedge clk);
        in_valid = 4'b0001;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 64'(out_valid), 64'd0);
        checkOutput("async_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 4'b0000;
        reset = 1'b0;
        sb.delete();
        m_ptr = 3;
        m_stalls = 0;
        applyStimulus(4'b0000, 1'b1, 64'h0);
        checkOutput("no_stale", 64'(obs_valid), 64'd0);
        applyStimulus(4'b1111, 1'b1, 64'hE0);
        checkOutput("first_grant", 64'(obs_ready), 64'b0001);
        applyStimulus(4'b0000, 1'b1, 64'h0);
        applyStimulus(4'b0000, 1'b1, 64'h0);

        // Single-slice instance: back-to-back transfers, one per cycle.
        out_ready1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 64'h2000 + 64'(k);
            #1;
            checkOutput("n1_in_ready", 64'(in_ready1), 64'd1);
            checkOutput("n1_out_valid", 64'(out_valid1), 64'(q1.size() != 0));
            if (q1.size() != 0) begin
                checkOutput("n1_out_data", out_data1, q1[0]);
                checkOutput("n1_out_sel", 64'(out_sel1), 64'd0);
                void'(q1.pop_front());
            end
            if (in_ready1) q1.push_back(in_data1);
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        if (q1.size() != 0) checkOutput("n1_last", out_data1, q1[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
